multi_cycle_ctrl: RTL and testbench
===================================

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL provide clk_i, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL provide rst_i, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL provide instr_op_i (input, 6) and funct_i (input, 6), the fields of the instruction register.
REQ-004 SHALL provide zero_i, input, 1, ALU zero flag for the current cycle.
REQ-005 SHALL provide mem_ready_i, input, 1, memory completes the current access this cycle.
REQ-006 SHALL provide the following outputs, each 1 bit: mem_req_o, MemRead_o, MemWrite_o, IorD_o (0=PC address, 1=ALUOut address), IRWrite_o, PCWrite_o, RegWrite_o, RegDst_o, MemToReg_o, JalSelect_o (write PC+4 to $31), ALUSrcA_o (0=PC, 1=rs).
REQ-007 SHALL provide ALUSrcB_o, output, 2 bits: 0=rt, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2.
REQ-008 SHALL provide PCSource_o, output, 2 bits: 0=ALU result, 1=ALUOut, 2=jump target, 3=rs.
REQ-009 SHALL provide ALU_op_o, output, 3 bits, using the same encoding as the single-cycle decoder.
REQ-010 SHALL provide the status outputs: state_o (output, 4), illegal_o (output, 1), instr_done_o (output, 1), instr_cnt_o (output, 16).

Function
REQ-011 SHALL use a 4-bit state register with these encodings: FETCH=0, DECODE=1, MEMADDR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9; state_o SHALL equal the state register.
REQ-012 FETCH SHALL behave as follows.
- Outputs: mem_req_o=1, MemRead_o=1, IorD_o=0, ALUSrcA_o=0, ALUSrcB_o=1, ALU_op_o=000, PCSource_o=0.
- When mem_ready_i=1: IRWrite_o=1 and PCWrite_o=1, and the next state is DECODE.
- When mem_ready_i=0: the block stays in FETCH with IRWrite_o=0 and PCWrite_o=0.
REQ-013 DECODE SHALL drive ALUSrcA_o=0, ALUSrcB_o=3, ALU_op_o=000, then branch on opcode and funct.
- lw(100011) or sw(101011) -> MEMADDR.
- R-type(000000) with funct 001000 (jr) -> JUMP.
- Other R-type, addi(001000) or slti(001010) -> EXEC.
- beq(000100) or bne(000101) -> BRANCH.
- j(000010) or jal(000011) -> JUMP.
- Any other opcode -> FETCH, with illegal_o=1 for that cycle.
REQ-014 MEMADDR SHALL drive ALUSrcA_o=1, ALUSrcB_o=2, ALU_op_o=000, then go to MEMRD for lw and MEMWR for sw.
REQ-015 MEMRD SHALL drive mem_req_o=1, MemRead_o=1, IorD_o=1, holding until mem_ready_i=1, then go to MEMWB.
REQ-016 MEMWB SHALL drive RegWrite_o=1, MemToReg_o=1, RegDst_o=0, then go to FETCH.
REQ-017 MEMWR SHALL drive mem_req_o=1, MemWrite_o=1, IorD_o=1, holding until mem_ready_i=1, then go to FETCH.
REQ-018 EXEC SHALL drive ALUSrcA_o=1 and select operands and ALU op by instruction, then go to RWB.
- R-type: ALUSrcB_o=0, ALU_op_o=100.
- addi: ALUSrcB_o=2, ALU_op_o=000.
- slti: ALUSrcB_o=2, ALU_op_o=010.
REQ-019 RWB SHALL drive RegWrite_o=1, MemToReg_o=0, RegDst_o=1 for R-type and 0 otherwise, then go to FETCH.
REQ-020 BRANCH SHALL drive ALUSrcA_o=1, ALUSrcB_o=0, PCSource_o=1 and ALU_op_o (001 for beq, 101 for bne).
- PCWrite_o = zero_i for beq and ~zero_i for bne.
- Next state is FETCH.
REQ-021 JUMP SHALL drive PCWrite_o=1 and PCSource_o (3 for jr, 2 otherwise).
- For jal it SHALL also drive RegWrite_o=1 and JalSelect_o=1.
- Next state is FETCH.
REQ-022 Every output not named for a state SHALL be 0 in that state; outputs SHALL be combinational decodes of the state and inputs.
REQ-023 instr_done_o SHALL be 1 for one cycle on each transition into FETCH from any state other than DECODE-illegal and reset.
REQ-024 instr_cnt_o SHALL increment on each instr_done_o and wrap from 16'hFFFF to 0.
REQ-025 mem_req_o SHALL remain asserted, with unchanged IorD_o, MemRead_o and MemWrite_o, for every cycle of a memory wait.
REQ-026 mem_ready_i SHALL be ignored in states with mem_req_o=0.
REQ-027 Unused state encodings 10-15 SHALL transition to FETCH on the next edge with all control outputs 0.

Reset
REQ-028 While rst_i=0, the state SHALL be FETCH and instr_cnt_o SHALL be 0, asynchronously, with mem_req_o=0 and all write enables (IRWrite_o, PCWrite_o, RegWrite_o, MemWrite_o) forced to 0.
REQ-029 On rst_i deassertion, the first fetch request SHALL appear on the next cycle with mem_req_o=1.
REQ-030 Reset asserted mid-access SHALL abandon the access immediately, with no write enable pulsed.

Verification
REQ-031 SHALL cover add (R-type) with mem_ready_i tied to 1.
- Stimulus: run the instruction through.
- Required: state sequence 0,1,6,7,0; RegWrite_o=1 only in state 7; instr_cnt_o=1.
REQ-032 SHALL cover lw with fetch wait 2 and data wait 3.
- Stimulus: mem_ready_i low 2 cycles in FETCH, low 3 cycles in MEMRD.
- Required: 11 cycles total; IRWrite_o pulses exactly once; MemToReg_o=1 in MEMWB.
REQ-033 SHALL cover beq and bne taken and not taken.
- beq with zero_i=1 and bne with zero_i=0: PCWrite_o=1 in BRANCH.
- Inverted zero_i: PCWrite_o=0 in BRANCH.
- All cases: PCSource_o=1.
REQ-034 SHALL cover jal and jr.
- jal: PCSource_o=2, JalSelect_o=1, RegWrite_o=1 in JUMP.
- jr: PCSource_o=3, RegWrite_o=0 in JUMP.
REQ-035 SHALL cover an illegal opcode.
- Stimulus: opcode 111111.
- Required: illegal_o=1 in DECODE, next state FETCH, instr_cnt_o unchanged.
REQ-036 SHALL cover reset mid-MEMWR and counter wrap.
- Reset: rst_i low during MEMWR drops MemWrite_o immediately.
- Wrap: preload the count by running 65536 instructions and check instr_cnt_o returns to 0.

Source files
------------

// File: rtl/multi_cycle_ctrl_if.sv
// Control bundle between the multi-cycle MIPS controller and its datapath.
// The master side is the controller; the slave side is the datapath.
interface multi_cycle_ctrl_if;
   logic [5:0]  instr_op_i;
   logic [5:0]  funct_i;
   logic        zero_i;
   logic        mem_ready_i;

   logic        mem_req_o;
   logic        MemRead_o;
   logic        MemWrite_o;
   logic        IorD_o;
   logic        IRWrite_o;
   logic        PCWrite_o;
   logic        RegWrite_o;
   logic        RegDst_o;
   logic        MemToReg_o;
   logic        JalSelect_o;
   logic        ALUSrcA_o;
   logic [1:0]  ALUSrcB_o;
   logic [1:0]  PCSource_o;
   logic [2:0]  ALU_op_o;

   logic [3:0]  state_o;
   logic        illegal_o;
   logic        instr_done_o;
   logic [15:0] instr_cnt_o;

   modport master (
      input  instr_op_i, funct_i, zero_i, mem_ready_i,
      output mem_req_o, MemRead_o, MemWrite_o, IorD_o, IRWrite_o, PCWrite_o,
             RegWrite_o, RegDst_o, MemToReg_o, JalSelect_o, ALUSrcA_o,
             ALUSrcB_o, PCSource_o, ALU_op_o,
             state_o, illegal_o, instr_done_o, instr_cnt_o
   );

   modport slave (
      output instr_op_i, funct_i, zero_i, mem_ready_i,
      input  mem_req_o, MemRead_o, MemWrite_o, IorD_o, IRWrite_o, PCWrite_o,
             RegWrite_o, RegDst_o, MemToReg_o, JalSelect_o, ALUSrcA_o,
             ALUSrcB_o, PCSource_o, ALU_op_o,
             state_o, illegal_o, instr_done_o, instr_cnt_o
   );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch, decode, memory, execute,
// branch and jump steps and counts retired instructions.
module multi_cycle_ctrl (
   input logic               clk_i,
   input logic               rst_i,
   multi_cycle_ctrl_if.master bus
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADDR = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXEC    = 4'd6,
      RWB     = 4'd7,
      BRANCH  = 4'd8,
      JUMP    = 4'd9
   } stateT;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   stateT       state;
   stateT       nextState;
   logic        doneQ;
   logic [15:0] instrCnt;

   logic isRtype, isJr, isLw, isSw, isAddi, isSlti, isBeq, isBne, isJ, isJal;

   logic       memReq, memRead, memWrite, iorD, irWrite, pcWrite;
   logic       regWrite, regDst, memToReg, jalSelect, srcA, illegal;
   logic [1:0] srcB, pcSource;
   logic [2:0] aluOp;
   logic       countEvent;

   assign isRtype = (bus.instr_op_i == OP_RTYPE);
   assign isJr    = isRtype && (bus.funct_i == FN_JR);
   assign isLw    = (bus.instr_op_i == OP_LW);
   assign isSw    = (bus.instr_op_i == OP_SW);
   assign isAddi  = (bus.instr_op_i == OP_ADDI);
   assign isSlti  = (bus.instr_op_i == OP_SLTI);
   assign isBeq   = (bus.instr_op_i == OP_BEQ);
   assign isBne   = (bus.instr_op_i == OP_BNE);
   assign isJ     = (bus.instr_op_i == OP_J);
   assign isJal   = (bus.instr_op_i == OP_JAL);

   // Per-state control decode and next-state selection; anything not set
   // in a state stays at its zero default.
   always_comb begin
      nextState = FETCH;
      memReq    = 1'b0;
      memRead   = 1'b0;
      memWrite  = 1'b0;
      iorD      = 1'b0;
      irWrite   = 1'b0;
      pcWrite   = 1'b0;
      regWrite  = 1'b0;
      regDst    = 1'b0;
      memToReg  = 1'b0;
      jalSelect = 1'b0;
      srcA      = 1'b0;
      srcB      = 2'd0;
      pcSource  = 2'd0;
      aluOp     = 3'b000;
      illegal   = 1'b0;
      case (state)
         FETCH: begin
            memReq  = 1'b1;
            memRead = 1'b1;
            srcB    = 2'd1;
            if (bus.mem_ready_i) begin
               irWrite   = 1'b1;
               pcWrite   = 1'b1;
               nextState = DECODE;
            end else begin
               nextState = FETCH;
            end
         end
         DECODE: begin
            srcB = 2'd3;
            if (isLw || isSw)                  nextState = MEMADDR;
            else if (isJr)                     nextState = JUMP;
            else if (isRtype || isAddi || isSlti) nextState = EXEC;
            else if (isBeq || isBne)           nextState = BRANCH;
            else if (isJ || isJal)             nextState = JUMP;
            else begin
               illegal   = 1'b1;
               nextState = FETCH;
            end
         end
         MEMADDR: begin
            srcA      = 1'b1;
            srcB      = 2'd2;
            nextState = isSw ? MEMWR : MEMRD;
         end
         MEMRD: begin
            memReq    = 1'b1;
            memRead   = 1'b1;
            iorD      = 1'b1;
            nextState = bus.mem_ready_i ? MEMWB : MEMRD;
         end
         MEMWB: begin
            regWrite  = 1'b1;
            memToReg  = 1'b1;
            nextState = FETCH;
         end
         MEMWR: begin
            memReq    = 1'b1;
            memWrite  = 1'b1;
            iorD      = 1'b1;
            nextState = bus.mem_ready_i ? FETCH : MEMWR;
         end
         EXEC: begin
            srcA = 1'b1;
            if (isRtype) begin
               srcB  = 2'd0;
               aluOp = 3'b100;
            end else if (isSlti) begin
               srcB  = 2'd2;
               aluOp = 3'b010;
            end else begin
               srcB  = 2'd2;
               aluOp = 3'b000;
            end
            nextState = RWB;
         end
         RWB: begin
            regWrite  = 1'b1;
            regDst    = isRtype;
            nextState = FETCH;
         end
         BRANCH: begin
            srcA      = 1'b1;
            srcB      = 2'd0;
            pcSource  = 2'd1;
            aluOp     = isBne ? 3'b101 : 3'b001;
            pcWrite   = isBne ? ~bus.zero_i : bus.zero_i;
            nextState = FETCH;
         end
         JUMP: begin
            pcWrite   = 1'b1;
            pcSource  = isJr ? 2'd3 : 2'd2;
            regWrite  = isJal;
            jalSelect = isJal;
            nextState = FETCH;
         end
         default: nextState = FETCH;
      endcase
   end

   // A retired instruction is any arrival in FETCH except waiting in FETCH
   // and the discard path of an illegal opcode.
   assign countEvent = (nextState == FETCH) && (state != FETCH) && !illegal;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state    <= FETCH;
         doneQ    <= 1'b0;
         instrCnt <= 16'd0;
      end else begin
         state <= nextState;
         doneQ <= countEvent;
         if (countEvent) begin
            instrCnt <= instrCnt + 16'd1;
         end
      end
   end

   // Holding reset silences every control line so an in-flight access is
   // dropped at once without a stray write strobe.
   assign bus.mem_req_o    = memReq    & rst_i;
   assign bus.MemRead_o    = memRead   & rst_i;
   assign bus.MemWrite_o   = memWrite  & rst_i;
   assign bus.IorD_o       = iorD      & rst_i;
   assign bus.IRWrite_o    = irWrite   & rst_i;
   assign bus.PCWrite_o    = pcWrite   & rst_i;
   assign bus.RegWrite_o   = regWrite  & rst_i;
   assign bus.RegDst_o     = regDst    & rst_i;
   assign bus.MemToReg_o   = memToReg  & rst_i;
   assign bus.JalSelect_o  = jalSelect & rst_i;
   assign bus.ALUSrcA_o    = srcA      & rst_i;
   assign bus.ALUSrcB_o    = srcB      & {2{rst_i}};
   assign bus.PCSource_o   = pcSource  & {2{rst_i}};
   assign bus.ALU_op_o     = aluOp     & {3{rst_i}};
   assign bus.illegal_o    = illegal   & rst_i;
   assign bus.state_o      = state;
   assign bus.instr_done_o = doneQ;
   assign bus.instr_cnt_o  = instrCnt;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: directed instruction cases plus
// randomized instruction streams compared against a per-instruction trace model.
module tb_multi_cycle_ctrl;

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;

   multi_cycle_ctrl_if bus();

   multi_cycle_ctrl dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic       memReq;
      logic       memRead;
      logic       memWrite;
      logic       iorD;
      logic       irWrite;
      logic       pcWrite;
      logic       regWrite;
      logic       regDst;
      logic       memToReg;
      logic       jalSel;
      logic       srcA;
      logic [1:0] srcB;
      logic [1:0] pcSrc;
      logic [2:0] aluOp;
      logic       illegal;
   } ctrlT;

   typedef struct {
      logic [3:0] st;
      ctrlT       c;
      logic       ready;
   } stepT;

   stepT        trace[$];
   int          checks = 0;
   int          errors = 0;
   int          cycleCount = 0;
   int          irPulses = 0;
   logic [15:0] modelCnt = 16'd0;
   logic        pendingDone = 1'b0;

   always @(posedge clk_i) cycleCount++;
   always @(negedge clk_i) if (bus.IRWrite_o) irPulses++;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic ctrlT observed();
      ctrlT c;
      c.memReq   = bus.mem_req_o;
      c.memRead  = bus.MemRead_o;
      c.memWrite = bus.MemWrite_o;
      c.iorD     = bus.IorD_o;
      c.irWrite  = bus.IRWrite_o;
      c.pcWrite  = bus.PCWrite_o;
      c.regWrite = bus.RegWrite_o;
      c.regDst   = bus.RegDst_o;
      c.memToReg = bus.MemToReg_o;
      c.jalSel   = bus.JalSelect_o;
      c.srcA     = bus.ALUSrcA_o;
      c.srcB     = bus.ALUSrcB_o;
      c.pcSrc    = bus.PCSource_o;
      c.aluOp    = bus.ALU_op_o;
      c.illegal  = bus.illegal_o;
      return c;
   endfunction

   function automatic bit isLegal(input logic [5:0] op);
      return op inside {6'h00, 6'h23, 6'h2b, 6'h08, 6'h0a, 6'h04, 6'h05, 6'h02, 6'h03};
   endfunction

   function automatic void pushStep(input int st, input ctrlT c, input logic ready);
      stepT s;
      s.st    = st[3:0];
      s.c     = c;
      s.ready = ready;
      trace.push_back(s);
   endfunction

   // Expected cycle-by-cycle behaviour of one whole instruction, written from
   // the instruction's point of view: which steps it takes and what each step drives.
   function automatic void buildTrace(input logic [5:0] op, input logic [5:0] funct,
                                      input logic zero, input int fw, input int mw);
      ctrlT c;
      trace.delete();
      for (int i = 0; i < fw; i++) begin
         c = '0; c.memReq = 1; c.memRead = 1; c.srcB = 2'd1;
         pushStep(0, c, 1'b0);
      end
      c = '0; c.memReq = 1; c.memRead = 1; c.srcB = 2'd1; c.irWrite = 1; c.pcWrite = 1;
      pushStep(0, c, 1'b1);
      c = '0; c.srcB = 2'd3; c.illegal = !isLegal(op);
      pushStep(1, c, 1'($urandom));
      if (!isLegal(op)) return;
      if (op == 6'h23 || op == 6'h2b) begin
         c = '0; c.srcA = 1; c.srcB = 2'd2;
         pushStep(2, c, 1'($urandom));
         for (int i = 0; i <= mw; i++) begin
            c = '0; c.memReq = 1; c.iorD = 1;
            if (op == 6'h23) c.memRead = 1; else c.memWrite = 1;
            pushStep(op == 6'h23 ? 3 : 5, c, (i == mw));
         end
         if (op == 6'h23) begin
            c = '0; c.regWrite = 1; c.memToReg = 1;
            pushStep(4, c, 1'($urandom));
         end
      end else if ((op == 6'h00 && funct == 6'h08) || op == 6'h02 || op == 6'h03) begin
         c = '0; c.pcWrite = 1;
         c.pcSrc = (op == 6'h00) ? 2'd3 : 2'd2;
         c.regWrite = (op == 6'h03);
         c.jalSel   = (op == 6'h03);
         pushStep(9, c, 1'($urandom));
      end else if (op == 6'h04 || op == 6'h05) begin
         c = '0; c.srcA = 1; c.pcSrc = 2'd1;
         c.aluOp   = (op == 6'h04) ? 3'b001 : 3'b101;
         c.pcWrite = (op == 6'h04) ? zero : !zero;
         pushStep(8, c, 1'($urandom));
      end else begin
         c = '0; c.srcA = 1;
         if (op == 6'h00) begin c.srcB = 2'd0; c.aluOp = 3'b100; end
         else if (op == 6'h0a) begin c.srcB = 2'd2; c.aluOp = 3'b010; end
         else begin c.srcB = 2'd2; c.aluOp = 3'b000; end
         pushStep(6, c, 1'($urandom));
         c = '0; c.regWrite = 1; c.regDst = (op == 6'h00);
         pushStep(7, c, 1'($urandom));
      end
   endfunction

   // Runs one instruction from its first FETCH cycle; abortAt >= 0 pulls
   // reset in that cycle and leaves the controller idle in FETCH.
   task automatic applyStimulus(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                                input int fw, input int mw, input int abortAt);
      buildTrace(op, funct, zero, fw, mw);
      bus.instr_op_i = op;
      bus.funct_i    = funct;
      bus.zero_i     = zero;
      foreach (trace[i]) begin
         bus.mem_ready_i = trace[i].ready;
         @(negedge clk_i);
         checkOutput($sformatf("op%0h c%0d state", op, i), bus.state_o, trace[i].st);
         checkOutput($sformatf("op%0h c%0d ctrl", op, i), observed(), trace[i].c);
         checkOutput($sformatf("op%0h c%0d done", op, i), bus.instr_done_o, (i == 0) ? pendingDone : 1'b0);
         checkOutput($sformatf("op%0h c%0d cnt", op, i), bus.instr_cnt_o, modelCnt);
         if (i == abortAt) begin
            rst_i = 1'b0;
            #1;
            checkOutput("abort memWrite", bus.MemWrite_o, 0);
            checkOutput("abort memReq", bus.mem_req_o, 0);
            checkOutput("abort state", bus.state_o, 0);
            checkOutput("abort cnt", bus.instr_cnt_o, 0);
            @(posedge clk_i);
            #1;
            rst_i       = 1'b1;
            modelCnt    = 16'd0;
            pendingDone = 1'b0;
            return;
         end
         @(posedge clk_i);
         #1;
      end
      if (isLegal(op)) begin
         modelCnt    = modelCnt + 16'd1;
         pendingDone = 1'b1;
      end else begin
         pendingDone = 1'b0;
      end
   endtask

   // Jumps the retired count close to its wrap point instead of retiring
   // tens of thousands of instructions one by one.
   task automatic preloadCount(input logic [15:0] value);
      bus.mem_ready_i = 1'b0;
      force dut.instrCnt = value;
      #1;
      release dut.instrCnt;
      @(posedge clk_i);
      #1;
      modelCnt    = value;
      pendingDone = 1'b0;
   endtask

   logic [5:0] legalOps [9] = '{6'h00, 6'h23, 6'h2b, 6'h08, 6'h0a, 6'h04, 6'h05, 6'h02, 6'h03};
   logic [5:0] badOps   [4] = '{6'h3f, 6'h01, 6'h10, 6'h22};

   initial begin
      int         c0, ir0, elapsed;
      bit         found;
      logic [5:0] op, funct;

      bus.instr_op_i  = 6'h00;
      bus.funct_i     = 6'h20;
      bus.zero_i      = 1'b0;
      bus.mem_ready_i = 1'b1;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      checkOutput("reset state", bus.state_o, 0);
      checkOutput("reset memReq", bus.mem_req_o, 0);
      checkOutput("reset irWrite", bus.IRWrite_o, 0);
      checkOutput("reset pcWrite", bus.PCWrite_o, 0);
      checkOutput("reset regWrite", bus.RegWrite_o, 0);
      checkOutput("reset memWrite", bus.MemWrite_o, 0);
      checkOutput("reset cnt", bus.instr_cnt_o, 0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;

      applyStimulus(6'h00, 6'h20, 1'b0, 0, 0, -1);
      checkOutput("add cnt", bus.instr_cnt_o, 1);

      c0  = cycleCount;
      ir0 = irPulses;
      applyStimulus(6'h23, 6'h00, 1'b0, 2, 3, -1);
      bus.mem_ready_i = 1'b0;
      found   = 0;
      elapsed = 0;
      for (int k = 0; k < 4 && !found; k++) begin
         @(negedge clk_i);
         if (bus.instr_done_o) begin
            found   = 1;
            elapsed = cycleCount - c0 + 1;
         end
         @(posedge clk_i);
         #1;
      end
      checkOutput("lw done seen", found, 1);
      checkOutput("lw cycles", elapsed, 11);
      checkOutput("lw irPulses", irPulses - ir0, 1);
      pendingDone = 1'b0;

      applyStimulus(6'h04, 6'h00, 1'b1, 0, 0, -1);
      applyStimulus(6'h04, 6'h00, 1'b0, 1, 0, -1);
      applyStimulus(6'h05, 6'h00, 1'b0, 0, 0, -1);
      applyStimulus(6'h05, 6'h00, 1'b1, 0, 0, -1);
      applyStimulus(6'h03, 6'h00, 1'b0, 0, 0, -1);
      applyStimulus(6'h00, 6'h08, 1'b0, 0, 0, -1);
      applyStimulus(6'h3f, 6'h00, 1'b0, 0, 0, -1);
      applyStimulus(6'h2b, 6'h00, 1'b0, 0, 1, -1);
      applyStimulus(6'h08, 6'h00, 1'b0, 0, 0, -1);
      applyStimulus(6'h0a, 6'h00, 1'b0, 0, 0, -1);

      applyStimulus(6'h2b, 6'h00, 1'b0, 0, 5, 4);

      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 9) == 0) op = badOps[$urandom_range(0, 3)];
         else                           op = legalOps[$urandom_range(0, 8)];
         funct = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom);
         applyStimulus(op, funct, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), -1);
      end

      preloadCount(16'hFFFD);
      repeat (3) applyStimulus(6'h02, 6'h00, 1'b0, 0, 0, -1);
      checkOutput("wrap cnt", bus.instr_cnt_o, 16'h0000);
      applyStimulus(6'h00, 6'h22, 1'b0, 0, 0, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
